// File: rtl/perf_pkg.sv
// Shared types and helpers for the performance counter bank.
package perf_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } chan_state_t;

  // Select width for a channel index; a single channel still needs a 1-bit select.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_chan.sv
// One counter channel: counts events in RUN and stall cycles in WAIT,
// with a sticky overflow flag.
module perf_chan
  import perf_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             evt_valid,
  input  logic             evt_miss,
  input  logic             cache_resp,
  output logic [WIDTH-1:0] evt_cnt,
  output logic [WIDTH-1:0] stall_cnt,
  output logic             overflow,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  chan_state_t      state_reg, state_next;
  logic [WIDTH-1:0] evt_reg, evt_next;
  logic [WIDTH-1:0] stall_reg, stall_next;
  logic             ovf_reg, ovf_next;
  logic             evt_inc, stall_inc;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_reg <= RUN;
      evt_reg   <= '0;
      stall_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      evt_reg   <= evt_next;
      stall_reg <= stall_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    evt_next   = evt_reg;
    stall_next = stall_reg;
    ovf_next   = ovf_reg;
    evt_inc    = 1'b0;
    stall_inc  = 1'b0;

    // Events arriving in WAIT, even alongside the response, are dropped.
    unique case (state_reg)
      RUN: begin
        if (evt_valid) begin
          evt_inc = 1'b1;
          if (evt_miss) state_next = WAIT;
        end
      end
      WAIT: begin
        stall_inc = 1'b1;
        if (cache_resp) state_next = RUN;
      end
      default: state_next = RUN;
    endcase

    if (evt_inc) begin
      if (evt_reg == ALL_ONES) begin
        ovf_next = 1'b1;
        evt_next = SATURATE ? ALL_ONES : '0;
      end else begin
        evt_next = evt_reg + ONE;
      end
    end

    if (stall_inc) begin
      if (stall_reg == ALL_ONES) begin
        ovf_next   = 1'b1;
        stall_next = SATURATE ? ALL_ONES : '0;
      end else begin
        stall_next = stall_reg + ONE;
      end
    end
  end

  assign evt_cnt   = evt_reg;
  assign stall_cnt = stall_reg;
  assign overflow  = ovf_reg;
  assign busy      = (state_reg == WAIT);

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of independent cache-gated event/stall counters with a registered
// CSR read port.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           evt_valid,
  input  logic [NUM_CH-1:0]           evt_miss,
  input  logic [NUM_CH-1:0]           cache_resp,
  input  logic                        clear,
  input  logic                        rd_en,
  input  logic [ch_idx_w(NUM_CH)-1:0] rd_sel,
  output logic                        rd_valid,
  output logic [WIDTH-1:0]            rd_evt,
  output logic [WIDTH-1:0]            rd_stall,
  output logic [NUM_CH-1:0]           overflow,
  output logic [NUM_CH-1:0]           busy
);

  localparam int SEL_W = ch_idx_w(NUM_CH);
  localparam int SLOTS = 1 << SEL_W;

  // Padded to a power of two so every rd_sel value indexes a slot;
  // unused slots read as zero.
  logic [WIDTH-1:0] evt_slot   [SLOTS];
  logic [WIDTH-1:0] stall_slot [SLOTS];

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < NUM_CH) begin : g_live
        perf_chan #(
          .WIDTH    (WIDTH),
          .SATURATE (SATURATE)
        ) u_chan (
          .clk        (clk),
          .rst_n      (rst_n),
          .clear      (clear),
          .evt_valid  (evt_valid[gi]),
          .evt_miss   (evt_miss[gi]),
          .cache_resp (cache_resp[gi]),
          .evt_cnt    (evt_slot[gi]),
          .stall_cnt  (stall_slot[gi]),
          .overflow   (overflow[gi]),
          .busy       (busy[gi])
        );
      end else begin : g_pad
        assign evt_slot[gi]   = '0;
        assign stall_slot[gi] = '0;
      end
    end
  endgenerate

  logic             rd_valid_reg;
  logic [WIDTH-1:0] rd_evt_reg;
  logic [WIDTH-1:0] rd_stall_reg;

  // Samples pre-update counter values; clear alone leaves held read data intact.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_reg <= 1'b0;
      rd_evt_reg   <= '0;
      rd_stall_reg <= '0;
    end else begin
      rd_valid_reg <= rd_en;
      if (rd_en) begin
        rd_evt_reg   <= evt_slot[rd_sel];
        rd_stall_reg <= stall_slot[rd_sel];
      end
    end
  end

  assign rd_valid = rd_valid_reg;
  assign rd_evt   = rd_evt_reg;
  assign rd_stall = rd_stall_reg;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench: three bank configurations driven in lock-step and
// compared against a behavioural per-channel model.
module tb_perf_counter_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       rd_en = 1'b0;
  logic [1:0] rd_sel = '0;
  logic [3:0] evt_valid = '0;
  logic [3:0] evt_miss = '0;
  logic [3:0] cache_resp = '0;

  logic       rd_valid_a, rd_valid_b, rd_valid_c;
  logic [7:0] rd_evt_a, rd_stall_a, rd_evt_b, rd_stall_b;
  logic [15:0] rd_evt_c, rd_stall_c;
  logic [3:0] overflow_a, busy_a, overflow_b, busy_b;
  logic [2:0] overflow_c, busy_c;

  // a: 4ch 8-bit wrap, b: 4ch 8-bit saturate, c: 3ch 16-bit wrap
  perf_counter_bank #(.NUM_CH(4), .WIDTH(8), .SATURATE(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .evt_valid(evt_valid), .evt_miss(evt_miss),
    .cache_resp(cache_resp), .clear(clear), .rd_en(rd_en), .rd_sel(rd_sel),
    .rd_valid(rd_valid_a), .rd_evt(rd_evt_a), .rd_stall(rd_stall_a),
    .overflow(overflow_a), .busy(busy_a));

  perf_counter_bank #(.NUM_CH(4), .WIDTH(8), .SATURATE(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .evt_valid(evt_valid), .evt_miss(evt_miss),
    .cache_resp(cache_resp), .clear(clear), .rd_en(rd_en), .rd_sel(rd_sel),
    .rd_valid(rd_valid_b), .rd_evt(rd_evt_b), .rd_stall(rd_stall_b),
    .overflow(overflow_b), .busy(busy_b));

  perf_counter_bank #(.NUM_CH(3), .WIDTH(16), .SATURATE(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .evt_valid(evt_valid[2:0]), .evt_miss(evt_miss[2:0]),
    .cache_resp(cache_resp[2:0]), .clear(clear), .rd_en(rd_en), .rd_sel(rd_sel),
    .rd_valid(rd_valid_c), .rd_evt(rd_evt_c), .rd_stall(rd_stall_c),
    .overflow(overflow_c), .busy(busy_c));

  logic        o_valid [3];
  logic [15:0] o_evt   [3];
  logic [15:0] o_stall [3];
  logic [3:0]  o_busy  [3];
  logic [3:0]  o_ovf   [3];

  assign o_valid[0] = rd_valid_a;
  assign o_valid[1] = rd_valid_b;
  assign o_valid[2] = rd_valid_c;
  assign o_evt[0]   = {8'h00, rd_evt_a};
  assign o_evt[1]   = {8'h00, rd_evt_b};
  assign o_evt[2]   = rd_evt_c;
  assign o_stall[0] = {8'h00, rd_stall_a};
  assign o_stall[1] = {8'h00, rd_stall_b};
  assign o_stall[2] = rd_stall_c;
  assign o_busy[0]  = busy_a;
  assign o_busy[1]  = busy_b;
  assign o_busy[2]  = {1'b0, busy_c};
  assign o_ovf[0]   = overflow_a;
  assign o_ovf[1]   = overflow_b;
  assign o_ovf[2]   = {1'b0, overflow_c};

  // Behavioural model
  int unsigned cfg_w   [3] = '{8, 8, 16};
  bit          cfg_sat [3] = '{1'b0, 1'b1, 1'b0};
  int          cfg_nch [3] = '{4, 4, 3};

  int unsigned m_evt   [3][4];
  int unsigned m_stall [3][4];
  bit          m_ovf   [3][4];
  bit          m_wait  [3][4];
  int unsigned m_rd_evt   [3];
  int unsigned m_rd_stall [3];
  bit          m_rd_valid [3];

  int checks = 0;
  int failures = 0;

  function automatic int unsigned bump(int k, int ch, int unsigned v);
    int unsigned lim = (32'd1 << cfg_w[k]) - 1;
    if (v == lim) begin
      m_ovf[k][ch] = 1'b1;
      return cfg_sat[k] ? lim : 0;
    end
    return v + 1;
  endfunction

  function automatic void model_update();
    for (int k = 0; k < 3; k++) begin
      if (rst_n !== 1'b1) begin
        m_rd_valid[k] = 1'b0;
        m_rd_evt[k]   = 0;
        m_rd_stall[k] = 0;
        for (int c = 0; c < 4; c++) begin
          m_evt[k][c] = 0; m_stall[k][c] = 0; m_ovf[k][c] = 0; m_wait[k][c] = 0;
        end
      end else begin
        m_rd_valid[k] = (rd_en === 1'b1);
        if (rd_en === 1'b1) begin
          if (int'(rd_sel) < cfg_nch[k]) begin
            m_rd_evt[k]   = m_evt[k][rd_sel];
            m_rd_stall[k] = m_stall[k][rd_sel];
          end else begin
            m_rd_evt[k]   = 0;
            m_rd_stall[k] = 0;
          end
        end
        for (int c = 0; c < cfg_nch[k]; c++) begin
          if (clear === 1'b1) begin
            m_evt[k][c] = 0; m_stall[k][c] = 0; m_ovf[k][c] = 0; m_wait[k][c] = 0;
          end else if (m_wait[k][c]) begin
            m_stall[k][c] = bump(k, c, m_stall[k][c]);
            if (cache_resp[c] === 1'b1) m_wait[k][c] = 1'b0;
          end else if (evt_valid[c] === 1'b1) begin
            m_evt[k][c] = bump(k, c, m_evt[k][c]);
            if (evt_miss[c] === 1'b1) m_wait[k][c] = 1'b1;
          end
        end
      end
    end
  endfunction

  function automatic logic [3:0] exp_busy(int k);
    logic [3:0] b = '0;
    for (int c = 0; c < 4; c++) b[c] = m_wait[k][c];
    return b;
  endfunction

  function automatic logic [3:0] exp_ovf(int k);
    logic [3:0] b = '0;
    for (int c = 0; c < 4; c++) b[c] = m_ovf[k][c];
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive_idle();
    clear = 1'b0; rd_en = 1'b0; rd_sel = '0;
    evt_valid = '0; evt_miss = '0; cache_resp = '0;
  endtask

  task automatic do_clear();
    drive_idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] sel);
    drive_idle();
    rd_en = 1'b1; rd_sel = sel;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_valid[k] !== 1'b0 || o_evt[k] !== 16'd0 || o_stall[k] !== 16'd0 ||
          o_busy[k] !== 4'd0 || o_ovf[k] !== 4'd0) begin
        failures++;
        $display("FAIL reset dut%0d: got v=%0b evt=%0d stall=%0d busy=%b ovf=%b, expected all zero",
                 k, o_valid[k], o_evt[k], o_stall[k], o_busy[k], o_ovf[k]);
      end
    end
  endtask

  task automatic test_plain_count();
    int busy_seen = 0;
    do_clear();
    for (int i = 0; i < 5; i++) begin
      evt_valid = 4'b0001;
      tick();
      if (busy_a[0] !== 1'b0) busy_seen++;
    end
    do_read(2'd0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_valid[k] !== 1'b1 || o_evt[k] !== 16'(m_rd_evt[k]) || o_stall[k] !== 16'(m_rd_stall[k])) begin
        failures++;
        $display("FAIL plain_read dut%0d: got v=%0b evt=%0d stall=%0d, expected v=1 evt=%0d stall=%0d",
                 k, o_valid[k], o_evt[k], o_stall[k], m_rd_evt[k], m_rd_stall[k]);
      end
    end
    checks++;
    if (rd_evt_a !== 8'd5 || rd_stall_a !== 8'd0 || busy_seen != 0) begin
      failures++;
      $display("FAIL plain_const: got evt=%0d stall=%0d busy_cycles=%0d, expected 5 0 0",
               rd_evt_a, rd_stall_a, busy_seen);
    end
  endtask

  task automatic test_miss_gating();
    int busy_cycles = 0;
    do_clear();
    evt_valid = 4'b0010; evt_miss = 4'b0010;
    tick();
    if (busy_a[1] === 1'b1) busy_cycles++;
    evt_miss = '0;
    for (int i = 0; i < 3; i++) begin
      evt_valid = 4'b0010;
      tick();
      if (busy_a[1] === 1'b1) busy_cycles++;
    end
    evt_valid = '0; cache_resp = 4'b0010;
    tick();
    if (busy_a[1] === 1'b1) busy_cycles++;
    cache_resp = '0;
    for (int i = 0; i < 2; i++) begin
      evt_valid = 4'b0010;
      tick();
      if (busy_a[1] === 1'b1) busy_cycles++;
    end
    do_read(2'd1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_valid[k] !== 1'b1 || o_evt[k] !== 16'(m_rd_evt[k]) || o_stall[k] !== 16'(m_rd_stall[k])) begin
        failures++;
        $display("FAIL miss_read dut%0d: got v=%0b evt=%0d stall=%0d, expected v=1 evt=%0d stall=%0d",
                 k, o_valid[k], o_evt[k], o_stall[k], m_rd_evt[k], m_rd_stall[k]);
      end
    end
    checks++;
    if (rd_evt_a !== 8'd3 || rd_stall_a !== 8'd4 || busy_cycles != 4) begin
      failures++;
      $display("FAIL miss_const: got evt=%0d stall=%0d busy_cycles=%0d, expected 3 4 4",
               rd_evt_a, rd_stall_a, busy_cycles);
    end
  endtask

  task automatic test_same_cycle_resp();
    do_clear();
    evt_valid = 4'b0100; evt_miss = 4'b0100;
    tick();
    drive_idle();
    tick();
    evt_valid = 4'b0100; cache_resp = 4'b0100;
    tick();
    checks++;
    if (busy_a[2] !== 1'b0 || busy_c[2] !== 1'b0 || o_busy[0] !== exp_busy(0)) begin
      failures++;
      $display("FAIL same_cycle_busy: got a=%b c=%b, expected bit2 low (model %b)",
               busy_a, busy_c, exp_busy(0));
    end
    do_read(2'd2);
    checks++;
    if (rd_evt_a !== 8'd1 || rd_stall_a !== 8'd2 || rd_evt_c !== 16'd1 || rd_stall_c !== 16'd2) begin
      failures++;
      $display("FAIL same_cycle_read: got a=%0d/%0d c=%0d/%0d, expected 1/2",
               rd_evt_a, rd_stall_a, rd_evt_c, rd_stall_c);
    end
  endtask

  task automatic test_wrap_saturate();
    do_clear();
    for (int i = 0; i < 257; i++) begin
      evt_valid = 4'b0001;
      tick();
    end
    do_read(2'd0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_evt[k] !== 16'(m_rd_evt[k]) || o_ovf[k] !== exp_ovf(k)) begin
        failures++;
        $display("FAIL wrap_model dut%0d: got evt=%0d ovf=%b, expected evt=%0d ovf=%b",
                 k, o_evt[k], o_ovf[k], m_rd_evt[k], exp_ovf(k));
      end
    end
    checks++;
    if (rd_evt_a !== 8'd1 || overflow_a[0] !== 1'b1 || rd_evt_b !== 8'd255 ||
        overflow_b[0] !== 1'b1 || rd_evt_c !== 16'd257 || overflow_c[0] !== 1'b0) begin
      failures++;
      $display("FAIL wrap_const: got a=%0d/%b b=%0d/%b c=%0d/%b, expected 1/1 255/1 257/0",
               rd_evt_a, overflow_a[0], rd_evt_b, overflow_b[0], rd_evt_c, overflow_c[0]);
    end
  endtask

  task automatic test_clear_priority();
    do_clear();
    // leave a stale overflow on ch0 so the clear has something to drop
    for (int i = 0; i < 256; i++) begin
      evt_valid = 4'b0001;
      tick();
    end
    for (int i = 0; i < 7; i++) begin
      evt_valid = 4'b1000;
      tick();
    end
    clear = 1'b1; evt_valid = 4'b1000; evt_miss = 4'b1000; rd_en = 1'b1; rd_sel = 2'd3;
    tick();
    drive_idle();
    checks++;
    if (rd_valid_a !== 1'b1 || rd_evt_a !== 8'd7 || rd_evt_b !== 8'd7 ||
        rd_valid_c !== 1'b1 || rd_evt_c !== 16'd0) begin
      failures++;
      $display("FAIL clear_read: got a=%0d b=%0d c=%0d (v %0b/%0b), expected 7 7 0 valid",
               rd_evt_a, rd_evt_b, rd_evt_c, rd_valid_a, rd_valid_c);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_ovf[k] !== 4'd0 || o_busy[k] !== 4'd0) begin
        failures++;
        $display("FAIL clear_flags dut%0d: got ovf=%b busy=%b, expected 0 0", k, o_ovf[k], o_busy[k]);
      end
    end
    for (int s = 0; s < 4; s++) begin
      do_read(2'(s));
      checks++;
      if (o_evt[0] !== 16'd0 || o_stall[0] !== 16'd0 || o_evt[1] !== 16'd0 || o_evt[2] !== 16'd0) begin
        failures++;
        $display("FAIL clear_counts sel%0d: got a=%0d/%0d b=%0d c=%0d, expected 0",
                 s, o_evt[0], o_stall[0], o_evt[1], o_evt[2]);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    do_clear();
    evt_valid = 4'b0001; evt_miss = 4'b0001;
    tick();
    drive_idle();
    rd_en = 1'b1; rd_sel = 2'd0;
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (busy_a !== 4'd0 || rd_valid_a !== 1'b0 || rd_evt_a !== 8'd0 || rd_stall_a !== 8'd0 ||
        busy_c !== 3'd0 || rd_valid_c !== 1'b0) begin
      failures++;
      $display("FAIL reset_wait: got busy=%b v=%0b evt=%0d stall=%0d c_busy=%b, expected zeros",
               busy_a, rd_valid_a, rd_evt_a, rd_stall_a, busy_c);
    end
    rst_n = 1'b1; rd_en = 1'b0;
    cache_resp = 4'b0001;
    tick();
    cache_resp = '0;
    tick();
    checks++;
    if (busy_a[0] !== 1'b0 || busy_b[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_resp_busy: got a=%b b=%b, expected bit0 low", busy_a, busy_b);
    end
    do_read(2'd0);
    checks++;
    if (rd_evt_a !== 8'd0 || rd_stall_a !== 8'd0 || rd_stall_c !== 16'd0) begin
      failures++;
      $display("FAIL reset_resp_counts: got evt=%0d stall=%0d c_stall=%0d, expected 0",
               rd_evt_a, rd_stall_a, rd_stall_c);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      rst_n      = ($urandom_range(0, 199) != 0);
      clear      = ($urandom_range(0, 149) == 0);
      evt_valid  = 4'($urandom);
      evt_miss   = 4'($urandom) & 4'($urandom);
      cache_resp = 4'($urandom) & 4'($urandom);
      rd_en      = 1'($urandom);
      rd_sel     = 2'($urandom);
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (o_valid[k] !== m_rd_valid[k] || o_evt[k] !== 16'(m_rd_evt[k]) ||
            o_stall[k] !== 16'(m_rd_stall[k]) || o_busy[k] !== exp_busy(k) ||
            o_ovf[k] !== exp_ovf(k)) begin
          failures++;
          bad++;
          if (bad <= 10)
            $display("FAIL random cyc%0d dut%0d: got v=%0b evt=%0d stall=%0d busy=%b ovf=%b, expected v=%0b evt=%0d stall=%0d busy=%b ovf=%b",
                     i, k, o_valid[k], o_evt[k], o_stall[k], o_busy[k], o_ovf[k],
                     m_rd_valid[k], m_rd_evt[k], m_rd_stall[k], exp_busy(k), exp_ovf(k));
        end
      end
    end
    rst_n = 1'b1;
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_plain_count();
    test_miss_gating();
    test_same_cycle_resp();
    test_wrap_saturate();
    test_clear_priority();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
